// File: rtl/matrix_print_tx.sv
// Prints an m x n row-major matrix from memory as unsigned decimal ASCII rows on a UART TX line (8N1).
// Latency: rd_en one cycle after start; fetch + convert <= 45 cycles per element; each byte 10*BAUD_DIV clocks.
// Backpressure: each byte is held until the serializer is idle; start is ignored while busy.
module matrix_print_tx #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  base_addr,
  input  logic [2:0]  dim_m,
  input  logic [2:0]  dim_n,
  output logic [8:0]  rd_addr,
  output logic        rd_en,
  input  logic [31:0] rd_data,
  output logic        uart_tx,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int BCW      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_CONV,
    S_SEND_DIG,
    S_SEND_SP,
    S_SEND_CR,
    S_SEND_LF,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Latched request and position within the matrix
  logic [8:0]  base_q;
  logic [2:0]  m_q, n_q;
  logic [2:0]  row_q, col_q;
  logic [4:0]  elem_q;

  // Decimal conversion working set
  logic [16:0]     val_q;
  logic [2:0]      pw_q;
  logic [3:0]      cur_q;
  logic [4:0][3:0] dig_q;
  logic [2:0]      ndig_q;
  logic [2:0]      dsel_q;
  logic [16:0]     weight;
  logic            err_q;

  // Serializer
  logic           tx_active;
  logic           tx_load;
  logic [7:0]     tx_byte;
  logic [8:0]     tx_shift;
  logic [3:0]     tx_bit;
  logic [BCW-1:0] baud_cnt;

  logic dims_ok;

  assign dims_ok = (dim_m != 3'd0) && (dim_m <= 3'd5) && (dim_n != 3'd0) && (dim_n <= 3'd5);
  assign rd_addr = base_q + {4'd0, elem_q};
  assign busy    = (state_q != S_IDLE) && !done;
  assign err     = err_q;

  // Place-value weight for the current subtraction stage
  always_comb begin
    weight = 17'd10;
    case (pw_q)
      3'd0:    weight = 17'd10000;
      3'd1:    weight = 17'd1000;
      3'd2:    weight = 17'd100;
      default: weight = 17'd10;
    endcase
  end

  // Controller state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Controller next state, memory strobe, byte handoff and done pulse
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    tx_load = 1'b0;
    tx_byte = 8'h00;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && dims_ok) state_d = S_FETCH;
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: state_d = S_CONV;
      S_CONV: begin
        if (pw_q == 3'd4) state_d = S_SEND_DIG;
      end
      S_SEND_DIG: begin
        if (!tx_active) begin
          tx_load = 1'b1;
          tx_byte = 8'h30 + {4'h0, dig_q[dsel_q]};
          if (dsel_q == ndig_q - 3'd1)
            state_d = (col_q == n_q - 3'd1) ? S_SEND_CR : S_SEND_SP;
        end
      end
      S_SEND_SP: begin
        if (!tx_active) begin
          tx_load = 1'b1;
          tx_byte = 8'h20;
          state_d = S_FETCH;
        end
      end
      S_SEND_CR: begin
        if (!tx_active) begin
          tx_load = 1'b1;
          tx_byte = 8'h0D;
          state_d = S_SEND_LF;
        end
      end
      S_SEND_LF: begin
        if (!tx_active) begin
          tx_load = 1'b1;
          tx_byte = 8'h0A;
          state_d = (row_q == m_q - 3'd1) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        // Wait for the final LF stop bit to finish before signalling done
        if (!tx_active) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latching, position counters and binary-to-decimal conversion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      m_q    <= '0;
      n_q    <= '0;
      row_q  <= '0;
      col_q  <= '0;
      elem_q <= '0;
      val_q  <= '0;
      pw_q   <= '0;
      cur_q  <= '0;
      dig_q  <= '0;
      ndig_q <= '0;
      dsel_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (dims_ok) begin
              base_q <= base_addr;
              m_q    <= dim_m;
              n_q    <= dim_n;
              row_q  <= '0;
              col_q  <= '0;
              elem_q <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          val_q  <= (rd_data > 32'd99999) ? 17'd99999 : rd_data[16:0];
          pw_q   <= '0;
          cur_q  <= '0;
          ndig_q <= '0;
          dsel_q <= '0;
        end
        S_CONV: begin
          if (pw_q == 3'd4) begin
            // Remainder is the units digit, always printed
            dig_q[ndig_q] <= val_q[3:0];
            ndig_q        <= ndig_q + 3'd1;
          end else if (val_q >= weight) begin
            val_q <= val_q - weight;
            cur_q <= cur_q + 4'd1;
          end else begin
            // A digit is kept once any non-zero digit has been seen
            if ((cur_q != 4'd0) || (ndig_q != 3'd0)) begin
              dig_q[ndig_q] <= cur_q;
              ndig_q        <= ndig_q + 3'd1;
            end
            pw_q  <= pw_q + 3'd1;
            cur_q <= '0;
          end
        end
        S_SEND_DIG: begin
          if (!tx_active && (dsel_q != ndig_q - 3'd1)) dsel_q <= dsel_q + 3'd1;
        end
        S_SEND_SP: begin
          if (!tx_active) begin
            col_q  <= col_q + 3'd1;
            elem_q <= elem_q + 5'd1;
          end
        end
        S_SEND_LF: begin
          if (!tx_active) begin
            row_q  <= row_q + 3'd1;
            col_q  <= '0;
            elem_q <= elem_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // 8N1 serializer: start bit, 8 data bits LSB first, stop bit, each BAUD_DIV clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_active <= 1'b0;
      uart_tx   <= 1'b1;
      tx_shift  <= '0;
      tx_bit    <= '0;
      baud_cnt  <= '0;
    end else if (!tx_active) begin
      if (tx_load) begin
        tx_active <= 1'b1;
        uart_tx   <= 1'b0;
        tx_shift  <= {1'b1, tx_byte};
        tx_bit    <= '0;
        baud_cnt  <= '0;
      end
    end else if (baud_cnt == BAUD_LAST) begin
      baud_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_active <= 1'b0;
      end else begin
        uart_tx  <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[8:1]};
        tx_bit   <= tx_bit + 4'd1;
      end
    end else begin
      baud_cnt <= baud_cnt + BCW'(1);
    end
  end

endmodule

// File: doc/matrix_print_tx.md
# matrix_print_tx

Output-side counterpart of the UART matrix input path. It reads an m×n matrix stored row-major at a base address in matrix memory and converts each element to unsigned decimal ASCII. It frames elements as space-separated rows ending in CR LF, and serializes the bytes on a UART TX pin (8N1). It is used by the display / result-print task after an operation or generation completes.

## Interface
Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz
- BAUD_RATE, 115200, UART bit rate; BAUD_DIV = CLK_FREQ/BAUD_RATE (217 at defaults)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  single-cycle request to print one matrix; sampled only in IDLE
- base_addr  input  9  first word address of the matrix; latched on start
- dim_m  input  3  row count, legal 1..5; latched on start
- dim_n  input  3  column count, legal 1..5; latched on start
- rd_addr  output  9  memory read address (base + element index)
- rd_en  output  1  memory read strobe; data valid on rd_data exactly one cycle later
- rd_data  input  32  memory read data, unsigned element value
- uart_tx  output  1  serial line, idle high
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse after the stop bit of the final LF
- err  output  1  one-cycle pulse when start is rejected for illegal dims

## Operation
- Reset values: uart_tx=1, busy=0, done=0, err=0, rd_en=0, rd_addr=0. Both FSMs are in idle, and all counters are 0.
- Controller states:
  - IDLE
  - FETCH: assert rd_en, rd_addr = base + r*dim_n + c.
  - WAIT: data returns.
  - CONV: binary to decimal.
  - SEND_DIG
  - SEND_SP
  - SEND_CR
  - SEND_LF
  - DONE
- IDLE handling of start:
  - If either dim is 0 or greater than 5: pulse err, stay IDLE, no bytes sent.
  - Otherwise: latch inputs, set busy, go to FETCH with r=c=0.
- CONV:
  - Values above 99999 saturate to 99999.
  - Digits are produced by sequential subtraction of 10000, 1000, 100, 10; the remainder is the units digit.
  - Leading zeros are suppressed. Value 0 prints a single "0".
  - The digit count (1..5) is stored with the digits.
- SEND_DIG: emit each digit as 0x30+d, most significant first.
- After the last digit:
  - If c < dim_n-1: go to SEND_SP (0x20), then c++, then FETCH.
  - Otherwise: go to SEND_CR (0x0D), then SEND_LF (0x0A).
  - After LF: if r < dim_m-1, then r++, c=0, FETCH. Otherwise go to DONE.
- Consequence: no trailing space on any row; every row, including the last, ends with CR LF.
- DONE: pulse done, clear busy, return to IDLE.
- Byte handoff to the serializer: load only when the serializer is idle. The serializer accepts the byte in the same cycle and goes busy the next cycle.
- Serializer frame: start bit 0, data bits LSB first, stop bit 1. Each bit is held exactly BAUD_DIV clocks.
- start while busy=1 is ignored, and the latched inputs are not disturbed.
- rst asserted mid-frame: uart_tx goes to 1 immediately (asynchronous). The frame is abandoned, done is not pulsed, and the block returns to IDLE.

## Timing
- start to rd_en: 1 cycle.
- rd_en to rd_data sampled: 1 cycle.
- CONV takes at most 45 cycles per element, negligible against one byte time.
- Byte time = 10*BAUD_DIV clocks (2170 at defaults).
- Back-to-back bytes: the next start bit begins no later than 2 cycles after the previous stop bit ends. Element fetch and CONV overlap the transmission of the preceding separator byte.
- done pulses 1 cycle after the final stop bit completes. busy falls in the same cycle.
- err pulses 1 cycle after the rejected start.

## Test plan
- 2×3 matrix at base 0x010 holding 1,2,3,4,5,6 -> decoded byte stream 31 20 32 20 33 0D 0A 34 20 35 20 36 0D 0A, then one done pulse; rd_addr visits 0x010..0x015 in order.
- 1×1 matrix holding 0 -> bytes 30 0D 0A; holding 12345 -> 31 32 33 34 35 0D 0A; holding 0x000F4240 (1,000,000) -> 39 39 39 39 39 0D 0A.
- Bit timing at defaults: measure uart_tx edges of byte 0x55 -> every bit exactly 217 clocks, start bit low, stop bit high, LSB first.
- start with dim_m=6, dim_n=2 -> err pulse next cycle, uart_tx stays 1, busy stays 0; same for dim_n=0.
- Second start pulsed while busy during a 5×5 print -> ignored; exactly 25 elements and 5 CR LF pairs emitted, one done.
- rst asserted during the data bits of the 3rd byte -> uart_tx=1 and busy=0 within the reset; a later start with 1×2 {7,8} prints 37 20 38 0D 0A correctly.
